patrol_controller: RTL

PATROL_CONTROLLER -- requirements
Module: patrol_controller

---
 rtl/patrol_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/patrol_controller.sv
// Patrol controller: sweeps a pan mechanism between 0 and POS_MAX with a
// fixed step cadence, accepts manual left/right requests, and raises an
// alarm on intrusion that holds for ALARM_HOLD cycles after the sensor clears.
//
// Step pulses: l_out / r_out are one-cycle, mutually exclusive pulses that
// the movement block consumes unconditionally (no back-pressure). pos is
// updated on the same edge that raises the pulse, so pos always reflects
// the pulse currently visible.
module patrol_controller #(
    parameter int POS_MAX    = 7,
    parameter int STEP_GAP   = 4,
    parameter int ALARM_HOLD = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         a,
    input  logic                         l_req,
    input  logic                         r_req,
    output logic                         l_out,
    output logic                         r_out,
    output logic                         y,
    output logic [$clog2(POS_MAX+1)-1:0] pos,
    output logic [1:0]                   state
);

    localparam int PW = $clog2(POS_MAX + 1);
    localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int HW = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;

    localparam logic [PW-1:0] POS_TOP   = PW'(POS_MAX);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STEP_GAP - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ALARM_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        ALARM = 2'b10,
        COOL  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pos_d;
    logic            dir_q, dir_d;      // auto-sweep direction: 0 = right, 1 = left
    logic [GW-1:0]   gap_q, gap_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            l_d, r_d, y_d;
    logic            manual;
    logic            go_left;

    // The state encoding is the externally visible state code.
    assign state = state_q;

    // Manual request wins only when exactly one side is asked for.
    assign manual  = l_req ^ r_req;
    assign go_left = manual ? l_req : dir_q;

    // State and datapath registers; every output comes straight from here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos     <= '0;
            dir_q   <= 1'b0;
            gap_q   <= '0;
            hold_q  <= '0;
            l_out   <= 1'b0;
            r_out   <= 1'b0;
            y       <= 1'b0;
        end else begin
            state_q <= state_d;
            pos     <= pos_d;
            dir_q   <= dir_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            l_out   <= l_d;
            r_out   <= r_d;
            y       <= y_d;
        end
    end

    // Next-state, step scheduling and alarm hold logic.
    always_comb begin
        state_d = state_q;
        pos_d   = pos;
        dir_d   = dir_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        l_d     = 1'b0;
        r_d     = 1'b0;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (a) begin
                    state_d = ALARM;
                end else if (en) begin
                    state_d = SWEEP;
                end
            end

            SWEEP: begin
                if (a) begin
                    // Intrusion beats any step slot on the same edge.
                    state_d = ALARM;
                    gap_d   = '0;
                end else if (!en) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 1'b1;
                end else begin
                    gap_d = '0;
                    if (go_left) begin
                        if (pos != '0) begin
                            pos_d = pos - 1'b1;
                            l_d   = 1'b1;
                            if (!manual && pos == PW'(1)) begin
                                dir_d = 1'b0;
                            end
                        end else if (!manual) begin
                            // Auto sweep blocked at the low end turns around.
                            dir_d = 1'b0;
                        end
                    end else begin
                        if (pos != POS_TOP) begin
                            pos_d = pos + 1'b1;
                            r_d   = 1'b1;
                            if (!manual && pos == POS_TOP - 1'b1) begin
                                dir_d = 1'b1;
                            end
                        end else if (!manual) begin
                            // Auto sweep blocked at the high end turns around.
                            dir_d = 1'b1;
                        end
                    end
                end
            end

            ALARM: begin
                gap_d = '0;
                if (!a) begin
                    state_d = COOL;
                    hold_d  = HOLD_LOAD;
                end
            end

            COOL: begin
                gap_d = '0;
                if (a) begin
                    state_d = ALARM;
                end else if (hold_q == '0) begin
                    state_d = en ? SWEEP : IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        y_d = (state_d == ALARM) || (state_d == COOL);
    end

endmodule
